aes_round_engine: RTL and testbench

Iterative AES encryption engine that applies one full AES round per clock cycle to a 128-bit state register. It performs the initial AddRoundKey, NR-1 full rounds and a final round without MixColumns, with valid/ready handshakes on input and output. The round count is set by a parameter, so one block serves AES-128, AES-192 and AES-256. Round keys come from an external key-schedule store addressed by this block.

---
 rtl/aes_round_engine.sv | 150 +++++++++++++++
 tb/tb_aes_round_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES encryptor: one full round per clock on a 128-bit state register.
// Round keys are read combinationally from an external key-schedule store via rk_idx.
module aes_round_engine #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_engine: NR must be 10, 12 or 14");
   end

   localparam logic [3:0] LAST = 4'(NR);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e       state_q, state_d;
   logic [3:0]   ctr_q, ctr_d;
   logic [127:0] data_q, data_d;
   logic [127:0] sub_shift, mixed;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // SubBytes fused with ShiftRows: out(r,c) = S(in(r,(c+r) mod 4)).
   always_comb begin
      sub_shift = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sub_shift[127 - 8*(4*c + r) -: 8] = sbox(data_q[127 - 8*(4*((c + r) % 4) + r) -: 8]);
         end
      end
   end

   always_comb begin : mix_columns
      logic [7:0] a0, a1, a2, a3;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      mixed = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = sub_shift[127 - 32*c -: 8];
         a1 = sub_shift[119 - 32*c -: 8];
         a2 = sub_shift[111 - 32*c -: 8];
         a3 = sub_shift[103 - 32*c -: 8];
         mixed[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mixed[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mixed[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mixed[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   always_comb begin
      state_d  = state_q;
      ctr_d    = ctr_q;
      data_d   = data_q;
      rk_idx   = '0;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = in_data ^ rk_data;
               ctr_d   = 4'd1;
               state_d = RUN;
            end
         end
         RUN: begin
            rk_idx = ctr_q;
            if (ctr_q == LAST) begin
               data_d  = sub_shift ^ rk_data;
               state_d = DONE;
            end else begin
               data_d = mixed ^ rk_data;
               ctr_d  = ctr_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  data_d  = in_data ^ rk_data;
                  ctr_d   = 4'd1;
                  state_d = RUN;
               end else begin
                  ctr_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = data_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors for NR=10/12/14, latency,
// backpressure, back-to-back acceptance and asynchronous reset mid-block.
module tb_aes_round_engine;
   logic         clk;
   logic         rst_n;
   logic         in_valid_a  [0:2];
   logic         in_ready_a  [0:2];
   logic [127:0] in_data_a   [0:2];
   logic [3:0]   rk_idx_a    [0:2];
   logic [127:0] rk_data_a   [0:2];
   logic         out_valid_a [0:2];
   logic         out_ready_a [0:2];
   logic [127:0] out_data_a  [0:2];
   logic         busy_a      [0:2];

   logic [127:0] rk_tab [0:2][0:15];
   logic [7:0]   sbox_tab [0:255];
   int           n_cmp;
   int           n_fail;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_round_engine #(.NR(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
      .in_data(in_data_a[0]), .rk_idx(rk_idx_a[0]), .rk_data(rk_data_a[0]),
      .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_data(out_data_a[0]),
      .busy(busy_a[0]));
   aes_round_engine #(.NR(12)) u_dut12 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
      .in_data(in_data_a[1]), .rk_idx(rk_idx_a[1]), .rk_data(rk_data_a[1]),
      .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_data(out_data_a[1]),
      .busy(busy_a[1]));
   aes_round_engine #(.NR(14)) u_dut14 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
      .in_data(in_data_a[2]), .rk_idx(rk_idx_a[2]), .rk_data(rk_data_a[2]),
      .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_data(out_data_a[2]),
      .busy(busy_a[2]));

   // Combinational key-schedule store, one table per instance.
   always_comb begin
      for (int k = 0; k < 3; k++) rk_data_a[k] = rk_tab[k][rk_idx_a[k]];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] bxtime(input logic [7:0] b);
      return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
   endfunction

   function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      logic [7:0] bb;
      acc = 8'h00;
      aa  = a;
      bb  = b;
      while (bb != 8'h00) begin
         if (bb[0]) acc = acc ^ aa;
         aa = bxtime(aa);
         bb = bb >> 1;
      end
      return acc;
   endfunction

   // S-box by brute-force inverse search and bitwise affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] cst;
      cst = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ cst[i];
         end
         sbox_tab[x] = s;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   task automatic expand(input int k, input logic [255:0] key, input int nk);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = bxtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk_tab[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Accept one block, check rk_idx stepping and exact latency, optionally hold
   // out_ready low for 'hold' cycles, then transfer and check return to IDLE.
   task automatic run_block(input int k, input logic [127:0] pt, input logic [127:0] exp,
                            input string nm, input int hold);
      int nr;
      nr = 10 + 2*k;
      in_data_a[k]   = pt;
      in_valid_a[k]  = 1'b1;
      out_ready_a[k] = 1'b0;
      n_cmp++;
      if (in_ready_a[k] !== 1'b1 || rk_idx_a[k] !== 4'd0) begin
         n_fail++;
         $display("FAIL %s accept: in_ready=%b rk_idx=%0d, want 1 / 0", nm, in_ready_a[k], rk_idx_a[k]);
      end
      for (int cyc = 1; cyc <= nr; cyc++) begin
         @(posedge clk); #1;
         in_valid_a[k] = 1'b0;
         n_cmp++;
         if (rk_idx_a[k] !== 4'(cyc) || out_valid_a[k] !== 1'b0 || in_ready_a[k] !== 1'b0 || busy_a[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s round %0d: rk_idx=%0d out_valid=%b in_ready=%b busy=%b, want %0d 0 0 1",
                     nm, cyc, rk_idx_a[k], out_valid_a[k], in_ready_a[k], busy_a[k], cyc);
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid_a[k] !== 1'b1 || rk_idx_a[k] !== 4'd0) begin
         n_fail++;
         $display("FAIL %s latency: out_valid=%b rk_idx=%0d, want 1 / 0", nm, out_valid_a[k], rk_idx_a[k]);
      end
      n_cmp++;
      if (out_data_a[k] !== exp) begin
         n_fail++;
         $display("FAIL %s ciphertext: got %h want %h", nm, out_data_a[k], exp);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_data_a[k] !== exp || out_valid_a[k] !== 1'b1 || in_ready_a[k] !== 1'b0 || busy_a[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hold %0d: data=%h valid=%b in_ready=%b busy=%b, want %h 1 0 1",
                     nm, h, out_data_a[k], out_valid_a[k], in_ready_a[k], busy_a[k], exp);
         end
      end
      out_ready_a[k] = 1'b1;
      #1;
      n_cmp++;
      if (in_ready_a[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready on transfer: got %b want 1", nm, in_ready_a[k]);
      end
      @(posedge clk); #1;
      out_ready_a[k] = 1'b0;
      n_cmp++;
      if (out_valid_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || in_ready_a[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s idle after transfer: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
                  nm, out_valid_a[k], busy_a[k], in_ready_a[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (out_valid_a[k] !== 1'b0 || out_data_a[k] !== 128'h0 || busy_a[k] !== 1'b0 || rk_idx_a[k] !== 4'd0) begin
            n_fail++;
            $display("FAIL reset dut%0d: out_valid=%b out_data=%h busy=%b rk_idx=%0d, want all 0",
                     k, out_valid_a[k], out_data_a[k], busy_a[k], rk_idx_a[k]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset release: in_ready=%b busy=%b, want 1 0", in_ready_a[0], busy_a[0]);
      end
   endtask

   task automatic test_fips_b();
      apply_reset();
      expand(0, KEY_B, 4);
      run_block(0, PT_B, CT_B, "fips_b", 0);
   endtask

   task automatic test_fips_c();
      apply_reset();
      expand(0, KEY_C, 4);
      expand(1, KEY_C, 6);
      expand(2, KEY_C, 8);
      run_block(0, PT_C, CT_C1, "fips_c1", 0);
      run_block(1, PT_C, CT_C2, "fips_c2", 0);
      run_block(2, PT_C, CT_C3, "fips_c3", 0);
   endtask

   task automatic test_backpressure();
      apply_reset();
      expand(0, KEY_C, 4);
      run_block(0, PT_C, CT_C1, "backpressure", 20);
   endtask

   // Block A under key C.1; the key store switches to key B in the DONE cycle,
   // so block B (accepted in that same cycle) must yield the FIPS-197 B result.
   task automatic test_back_to_back();
      apply_reset();
      expand(0, KEY_C, 4);
      in_data_a[0]   = PT_C;
      in_valid_a[0]  = 1'b1;
      out_ready_a[0] = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk); #1;
         in_valid_a[0] = cyc[0];
         in_data_a[0]  = PT_B;
         n_cmp++;
         if (in_ready_a[0] !== 1'b0 || rk_idx_a[0] !== 4'(cyc)) begin
            n_fail++;
            $display("FAIL b2b run A %0d: in_ready=%b rk_idx=%0d, want 0 / %0d", cyc, in_ready_a[0], rk_idx_a[0], cyc);
         end
      end
      @(posedge clk); #1;
      in_valid_a[0] = 1'b1;
      expand(0, KEY_B, 4);
      #1;
      n_cmp++;
      if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== CT_C1 || in_ready_a[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b block A: valid=%b data=%h in_ready=%b, want 1 %h 1",
                  out_valid_a[0], out_data_a[0], in_ready_a[0], CT_C1);
      end
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk); #1;
         in_valid_a[0] = 1'b0;
         n_cmp++;
         if (out_valid_a[0] !== 1'b0 || rk_idx_a[0] !== 4'(cyc) || busy_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b run B %0d: out_valid=%b rk_idx=%0d busy=%b, want 0 %0d 1",
                     cyc, out_valid_a[0], rk_idx_a[0], busy_a[0], cyc);
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== CT_B) begin
         n_fail++;
         $display("FAIL b2b block B: valid=%b data=%h, want 1 %h", out_valid_a[0], out_data_a[0], CT_B);
      end
      @(posedge clk); #1;
      out_ready_a[0] = 1'b0;
      n_cmp++;
      if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b drain: out_valid=%b busy=%b, want 0 0", out_valid_a[0], busy_a[0]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      expand(0, KEY_C, 4);
      in_data_a[0]   = PT_C;
      in_valid_a[0]  = 1'b1;
      out_ready_a[0] = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         in_valid_a[0] = 1'b0;
      end
      n_cmp++;
      if (rk_idx_a[0] !== 4'd5 || out_data_a[0] === 128'h0) begin
         n_fail++;
         $display("FAIL reset_mid round5: rk_idx=%0d state=%h, want 5 / nonzero", rk_idx_a[0], out_data_a[0]);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_data_a[0] !== 128'h0 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || rk_idx_a[0] !== 4'd0 || in_ready_a[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid async: data=%h valid=%b busy=%b rk_idx=%0d in_ready=%b, want 0 0 0 0 1",
                  out_data_a[0], out_valid_a[0], busy_a[0], rk_idx_a[0], in_ready_a[0]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_block(0, PT_C, CT_C1, "reset_mid_c1", 0);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid_a[k]  = 1'b0;
         in_data_a[k]   = '0;
         out_ready_a[k] = 1'b0;
         for (int r = 0; r < 16; r++) rk_tab[k][r] = '0;
      end
      build_sbox();
      test_reset();
      test_fips_b();
      test_fips_c();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
